// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read arbiter and its helpers.
// Holds the FSM encoding and the default register-file geometry.
package regfile_read_arbiter_pkg;

  // Default register-file geometry: 32 words of 32 bits, 5-bit select.
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = 2;

  // Arbiter FSM encoding. Values are fixed so that other blocks
  // observing the state (debug taps, assertions) agree on the meaning.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage : regfile_read_arbiter_pkg

// File: rtl/regfile_read_arbiter_picker.sv
// Round-robin priority picker: finds the first valid requester at or
// after the rotating pointer, wrapping around, and reports it both as a
// one-hot grant vector and as a binary id. Purely combinational.
module rr_priority_picker
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic w_found;

  // Scan NUM_REQ positions starting at rr_ptr; the id arithmetic wraps
  // naturally because NUM_REQ is a power of two and ID_W = log2(NUM_REQ).
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_found  = 1'b0;
    grant_id = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = rr_ptr + ID_W'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        grant_id = w_idx;
      end
    end
  end

  // Expand the winning id into a one-hot grant, all zero when nobody asks.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = w_found && (grant_id == ID_W'(gi));
    end
  endgenerate

endmodule : rr_priority_picker

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read mux between NUM_REQ requesters.
// A request is accepted in IDLE, its address is registered onto the mux
// select, the mux output is captured one cycle later and then offered on
// the response bus until the consumer takes it.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         mux_address,
  input  logic [DATA_W-1:0]         mux_data,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  input  logic                      resp_ready
);

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_win_id;
  logic [ADDR_W-1:0]  r_mux_address;
  logic               r_resp_valid;
  logic [ID_W-1:0]    r_resp_id;
  logic [DATA_W-1:0]  r_resp_data;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;
  logic [ID_W-1:0]    w_rr_ptr_next;
  logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];

  // Unpack the flat address bus so the winner can be selected by id.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_id  (w_grant_id)
  );

  // The pointer moves just past the winner so it has lowest priority next.
  assign w_rr_ptr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and accept strobe. Nothing is accepted while reset is held,
  // so a request presented during reset is never acknowledged.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst_n && (|req_valid)) begin
          w_req_ready  = w_grant;
          w_accept     = 1'b1;
          w_state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Arbitration bookkeeping: mux select, winner id and round-robin pointer
  // change only on an accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_win_id      <= '0;
      r_mux_address <= '0;
    end else if (w_accept) begin
      r_rr_ptr      <= w_rr_ptr_next;
      r_win_id      <= w_grant_id;
      r_mux_address <= w_addr_arr[w_grant_id];
    end
  end

  // Response registers: capture the settled mux output after SAMPLE and
  // hold it until the consumer accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else if (r_state == ST_SAMPLE) begin
      r_resp_valid <= 1'b1;
      r_resp_id    <= r_win_id;
      r_resp_data  <= mux_data;
    end else if ((r_state == ST_RESP) && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign req_ready   = w_req_ready;
  assign mux_address = r_mux_address;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_data   = r_resp_data;

endmodule : regfile_read_arbiter

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model.
module tb_regfile_read_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]    req_ready;
  logic [AW-1:0]    mux_address;
  logic [DW-1:0]    mux_data;
  logic             resp_valid;
  logic [IW-1:0]    resp_id;
  logic [DW-1:0]    resp_data;
  logic             resp_ready = 1'b0;

  always #5 clk = ~clk;

  // Behavioural register file: word K holds 0x100 + K.
  assign mux_data = 32'h100 + {27'd0, mux_address};

  regfile_read_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ID_W    (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .mux_address (mux_address),
    .mux_data    (mux_data),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .resp_ready  (resp_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one outstanding transaction at most, tracked by its accept cycle.
  bit          m_known = 0;
  bit          m_out   = 0;
  int          m_acc   = 0;
  int          m_cycle = 0;
  int          m_rr    = 0;
  int          m_wid   = 0;
  int          m_last_win = -1;
  logic [AW-1:0] m_addr = '0;
  logic [IW-1:0] m_id   = '0;
  logic [DW-1:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, m_cycle);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int start);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (start + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model
  // across the rising edge.
  task automatic step(input bit rst, input logic [NR-1:0] v,
                      input logic [NR*AW-1:0] a, input bit rr);
    int win;
    bit vexp;
    logic [NR-1:0] exp_ready;
    rst_n = rst;
    req_valid = v;
    req_addr = a;
    resp_ready = rr;
    #1;
    vexp = m_out && (m_cycle >= m_acc + 2);
    win = -1;
    exp_ready = '0;
    if (rst && m_known && !m_out && (v != '0)) begin
      win = pick(v, m_rr);
      exp_ready[win] = 1'b1;
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (m_known) begin
      check("resp_valid", 32'(resp_valid), 32'(vexp));
      check("resp_id", 32'(resp_id), 32'(m_id));
      check("resp_data", resp_data, m_data);
      check("mux_address", 32'(mux_address), 32'(m_addr));
    end
    m_last_win = win;
    @(posedge clk);
    if (!rst) begin
      m_known = 1;
      m_out = 0;
      m_rr = 0;
      m_addr = '0;
      m_id = '0;
      m_data = '0;
    end else if (win >= 0) begin
      m_out = 1;
      m_acc = m_cycle;
      m_wid = win;
      m_addr = a[win*AW +: AW];
      m_rr = (win + 1) % NR;
      $display("[TB] cycle %0d grant id=%0d addr=%0d", m_cycle, win, m_addr);
    end else if (m_out && (m_cycle == m_acc + 1)) begin
      m_id = IW'(m_wid);
      m_data = 32'h100 + {27'd0, m_addr};
    end else if (vexp && rr) begin
      m_out = 0;
      $display("[TB] cycle %0d response id=%0d data=%h taken", m_cycle, m_id, m_data);
    end
    m_cycle++;
    @(negedge clk);
  endtask

  logic [NR-1:0]    pend;
  logic [AW-1:0]    pa [NR];
  logic [NR*AW-1:0] av;

  initial begin
    @(negedge clk);

    // Reset held two cycles with every requester asking.
    step(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1);
    step(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1);

    // Single request from requester 2 at address 20.
    step(1, 4'b0100, {5'd0, 5'd20, 5'd0, 5'd0}, 1);
    repeat (4) step(1, 4'b0000, {5'd0, 5'd20, 5'd0, 5'd0}, 1);

    // Reset, then round-robin with everyone valid: grants 0,1,2,3,0.
    step(0, 4'b0000, '0, 1);
    repeat (15) step(1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1);

    // Backpressure: requester 0 served, requester 1 waits behind a stalled
    // response consumer.
    step(0, 4'b0000, '0, 1);
    step(1, 4'b0011, {5'd0, 5'd0, 5'd7, 5'd9}, 0);
    step(1, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd9}, 0);
    repeat (6) step(1, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd9}, 0);
    repeat (5) step(1, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd9}, 1);

    // Wrap: grant 2 leaves the pointer at 3, then 3 wins before 0.
    step(0, 4'b0000, '0, 1);
    step(1, 4'b0100, {5'd0, 5'd12, 5'd0, 5'd0}, 1);
    repeat (3) step(1, 4'b0000, '0, 1);
    repeat (7) step(1, 4'b1001, {5'd30, 5'd0, 5'd0, 5'd5}, 1);

    // Reset while in SAMPLE: that request must never respond, and priority
    // restarts from requester 0.
    step(1, 4'b0100, {5'd0, 5'd17, 5'd0, 5'd0}, 1);
    step(0, 4'b0000, '0, 1);
    repeat (3) step(1, 4'b0000, '0, 1);
    repeat (4) step(1, 4'b1111, {5'd11, 5'd10, 5'd9, 5'd8}, 1);

    // Random traffic obeying the requester contract.
    pend = '0;
    for (int i = 0; i < NR; i++) pa[i] = '0;
    repeat (400) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 9) < 3) begin
            pend[i] = 1'b1;
            pa[i] = AW'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      for (int i = 0; i < NR; i++) av[i*AW +: AW] = pa[i];
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, pend, av,
           ($urandom_range(0, 3) != 0));
      if (m_last_win >= 0) pend[m_last_win] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_read_arbiter
